// File: rtl/bitrev_pkg.sv
// bitrev_pkg: shared definitions for the bitrev frame arbiter.
//   clog2/idx_width : index-width helpers (tag and pointer widths)
//   frame_len       : words per frame, N = 2^K
//   arb_state_e     : input-side arbiter FSM state
package bitrev_pkg;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Width of an index into n entries, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    function automatic int unsigned frame_len(input int unsigned k);
        return 32'd1 << k;
    endfunction

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCK
    } arb_state_e;

endpackage

// File: rtl/bitrev_tag_fifo.sv
// bitrev_tag_fifo: TD-deep FIFO of frame-owner tags.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i, tag_i : enqueue a tag (ignored when full)
//   pop_i         : dequeue head tag (ignored when empty)
//   tag_o         : head tag
//   full_o, empty_o : occupancy flags
module bitrev_tag_fifo
    import bitrev_pkg::*;
#(
    parameter int unsigned TD = 2,
    parameter int unsigned TW = 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic [TW-1:0] tag_i,
    input  logic          pop_i,
    output logic [TW-1:0] tag_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int unsigned PW = idx_width(TD);
    localparam int unsigned CW = clog2(TD + 1);

    logic [TW-1:0] mem_q [TD];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          push_ok, pop_ok;

    assign full_o  = (cnt_q == CW'(TD));
    assign empty_o = (cnt_q == '0);
    assign tag_o   = mem_q[rd_q];
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q + CW'(push_ok) - CW'(pop_ok);
        if (push_ok) wr_d = (wr_q == PW'(TD - 1)) ? '0 : wr_q + 1'b1;
        if (pop_ok)  rd_d = (rd_q == PW'(TD - 1)) ? '0 : rd_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int unsigned i = 0; i < TD; i++) mem_q[i] <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            if (push_ok) mem_q[wr_q] <= tag_i;
        end
    end

endmodule

// File: rtl/bitrev_arb.sv
// bitrev_arb: frame-granular round-robin arbiter sharing one bitrev core
// between NR valid/ready requesters.
//   req_valid_i/req_data_i/req_ready_o : requester input streams (r at [r*DW +: DW])
//   rsp_valid_o/rsp_data_o/rsp_ready_i : per-requester output streams (data replicated)
//   core_valid_o/core_data_o/core_ready_i : to the core input
//   core_valid_i/core_data_i/core_ready_o : from the core output
//   busy_o : input frame locked or frames in flight
module bitrev_arb
    import bitrev_pkg::*;
#(
    parameter int unsigned K  = 10,
    parameter int unsigned DW = 32,
    parameter int unsigned NR = 2,
    parameter int unsigned TD = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [NR-1:0]    req_valid_i,
    input  logic [NR*DW-1:0] req_data_i,
    output logic [NR-1:0]    req_ready_o,
    output logic [NR-1:0]    rsp_valid_o,
    output logic [NR*DW-1:0] rsp_data_o,
    input  logic [NR-1:0]    rsp_ready_i,
    output logic             core_valid_o,
    output logic [DW-1:0]    core_data_o,
    input  logic             core_ready_i,
    input  logic             core_valid_i,
    input  logic [DW-1:0]    core_data_i,
    output logic             core_ready_o,
    output logic             busy_o
);

    localparam int unsigned TW = idx_width(NR);
    // N is a power of two, so the last beat index is all ones in K bits.
    localparam logic [K-1:0] LAST = K'(frame_len(K) - 32'd1);

    typedef logic [TW-1:0] tag_t;

    arb_state_e   state_q, state_d;
    tag_t         grant_q, grant_d, rr_q, rr_d, head;
    logic [K-1:0] in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
    logic         push, pop, fifo_full, fifo_empty, found;
    logic [NR-1:0] vshift;
    int unsigned  cand;

    bitrev_tag_fifo #(
        .TD(TD),
        .TW(TW)
    ) u_tag_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push_i (push),
        .tag_i  (grant_q),
        .pop_i  (pop),
        .tag_o  (head),
        .full_o (fifo_full),
        .empty_o(fifo_empty)
    );

    // Input side: round-robin grant in IDLE, frame-long lock in LOCK.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        rr_d         = rr_q;
        in_cnt_d     = in_cnt_q;
        push         = 1'b0;
        found        = 1'b0;
        cand         = 0;
        vshift       = '0;
        req_ready_o  = '0;
        core_valid_o = 1'b0;
        core_data_o  = '0;
        unique case (state_q)
            ARB_IDLE: begin
                if (!fifo_full) begin
                    for (int unsigned i = 0; i < NR; i++) begin
                        cand   = (32'(rr_q) + i) % NR;
                        vshift = req_valid_i >> cand;
                        if (!found && vshift[0]) begin
                            found   = 1'b1;
                            grant_d = tag_t'(cand);
                            state_d = ARB_LOCK;
                        end
                    end
                end
            end
            ARB_LOCK: begin
                for (int unsigned r = 0; r < NR; r++) begin
                    if (grant_q == tag_t'(r)) begin
                        core_valid_o   = req_valid_i[r];
                        core_data_o    = req_data_i[r*DW +: DW];
                        req_ready_o[r] = core_ready_i;
                    end
                end
                if (core_valid_o && core_ready_i) begin
                    in_cnt_d = in_cnt_q + 1'b1;
                    if (in_cnt_q == LAST) begin
                        push    = 1'b1;
                        rr_d    = tag_t'((32'(grant_q) + 32'd1) % NR);
                        state_d = ARB_IDLE;
                    end
                end
            end
        endcase
    end

    // Output side: steer the core's output to the head tag's port, no added latency.
    always_comb begin
        rsp_valid_o  = '0;
        rsp_data_o   = '0;
        core_ready_o = 1'b0;
        out_cnt_d    = out_cnt_q;
        pop          = 1'b0;
        if (!fifo_empty) begin
            for (int unsigned r = 0; r < NR; r++) begin
                if (head == tag_t'(r)) begin
                    rsp_valid_o[r] = core_valid_i;
                    core_ready_o   = rsp_ready_i[r];
                end
            end
            rsp_data_o = {NR{core_data_i}};
            if (core_valid_i && core_ready_o) begin
                out_cnt_d = out_cnt_q + 1'b1;
                pop       = (out_cnt_q == LAST);
            end
        end
    end

    assign busy_o = (state_q == ARB_LOCK) | ~fifo_empty;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ARB_IDLE;
            grant_q   <= '0;
            rr_q      <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_q      <= rr_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
        end
    end

endmodule

// File: tb/tb_bitrev_arb.sv
// tb_bitrev_arb: scoreboard bench for bitrev_arb with a behavioural bitrev core.
module tb_bitrev_arb;

    localparam int K  = 4;
    localparam int N  = 16;
    localparam int DW = 32;
    localparam int NR = 2;
    localparam int TD = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NR-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
    logic [NR*DW-1:0] req_data, rsp_data;
    logic             dut_core_valid, dut_core_ready, busy;
    logic [DW-1:0]    dut_core_data;
    logic             cm_valid, cm_ready;
    logic [DW-1:0]    cm_data;

    always #5 clk = ~clk;

    bitrev_arb #(.K(K), .DW(DW), .NR(NR), .TD(TD)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_ready_o (req_ready),
        .rsp_valid_o (rsp_valid),
        .rsp_data_o  (rsp_data),
        .rsp_ready_i (rsp_ready),
        .core_valid_o(dut_core_valid),
        .core_data_o (dut_core_data),
        .core_ready_i(cm_ready),
        .core_valid_i(cm_valid),
        .core_data_i (cm_data),
        .core_ready_o(dut_core_ready),
        .busy_o      (busy)
    );

    int n_vec = 0;
    int n_mis = 0;

    logic [DW-1:0] send_q  [NR][$];
    logic [DW-1:0] in_exp  [NR][$];
    logic [DW-1:0] out_exp [NR][$];
    int            grant_log[$];
    int            in_beat = 0;
    int            sent[NR];
    int            hold[NR];
    int            pause_beat[NR];
    int            pause_len = 0;
    logic [NR-1:0] hold_rsp = '0;
    logic          rand_rdy = 1'b0;

    function automatic int bitrev(input int j);
        int r = 0;
        for (int b = 0; b < K; b++) if ((j >> b) & 1) r += 1 << (K - 1 - b);
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_mis++;
        $display("FAIL %s: event not seen, want it within bound", name);
    endtask

    // Behavioural core: bit-reverses each N-word frame, holds up to two frames.
    logic [DW-1:0] cm_in[$];
    logic [DW-1:0] cm_out[$];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cm_in.delete();
            cm_out.delete();
            cm_valid <= 1'b0;
            cm_data  <= '0;
            cm_ready <= 1'b0;
        end else begin
            if (dut_core_valid && cm_ready) begin
                cm_in.push_back(dut_core_data);
                if (cm_in.size() == N) begin
                    for (int j = 0; j < N; j++) cm_out.push_back(cm_in[bitrev(j)]);
                    cm_in.delete();
                end
            end
            if (cm_valid && dut_core_ready) void'(cm_out.pop_front());
            cm_valid <= (cm_out.size() != 0);
            cm_data  <= (cm_out.size() != 0) ? cm_out[0] : '0;
            cm_ready <= (cm_out.size() < 2 * N);
        end
    end

    // Requester / response-ready driver.
    initial begin : drv
        logic [NR-1:0] hs;
        req_valid = '0;
        req_data  = 'x;
        rsp_ready = '0;
        forever begin
            @(negedge clk);
            hs = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int r = 0; r < NR; r++) begin
                if (!rst_n) begin
                    hold[r] = 0;
                    sent[r] = 0;
                end else if (hs[r] && send_q[r].size() > 0) begin
                    void'(send_q[r].pop_front());
                    sent[r] = (sent[r] + 1) % N;
                    if (sent[r] == pause_beat[r]) hold[r] = pause_len;
                end
                if (!rst_n || send_q[r].size() == 0) begin
                    req_valid[r]         = 1'b0;
                    req_data[r*DW +: DW] = 'x;
                end else begin
                    req_data[r*DW +: DW] = send_q[r][0];
                    if (hold[r] > 0) begin
                        req_valid[r] = 1'b0;
                        hold[r]--;
                    end else begin
                        req_valid[r] = 1'b1;
                    end
                end
                rsp_ready[r] = !rst_n ? 1'b0 : hold_rsp[r] ? 1'b0 :
                               rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
        end
    end

    // Monitor: input steering, grant order, and per-port response scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (dut_core_valid && cm_ready) begin
                int owner = -1;
                for (int r = 0; r < NR; r++) if (req_ready[r]) owner = r;
                check("in_ready_onehot", 64'($countones(req_ready)), 64'd1);
                if (owner >= 0) begin
                    if (in_beat == 0) grant_log.push_back(owner);
                    if (in_exp[owner].size() == 0) fail_now("in_unexpected_beat");
                    else check("in_data", 64'(dut_core_data), 64'(in_exp[owner].pop_front()));
                end
                in_beat = (in_beat + 1) % N;
            end
            for (int r = 0; r < NR; r++) begin
                if (rsp_valid[r] && rsp_ready[r]) begin
                    if (out_exp[r].size() == 0) fail_now($sformatf("rsp%0d_unexpected", r));
                    else check($sformatf("rsp%0d_data", r), 64'(rsp_data[r*DW +: DW]),
                               64'(out_exp[r].pop_front()));
                end
            end
            if (rsp_valid != '0) check("rsp_valid_onehot", 64'($countones(rsp_valid)), 64'd1);
        end
    end

    task automatic queue_frame(input int r, input bit rnd, input int base);
        logic [DW-1:0] w[N];
        for (int i = 0; i < N; i++) w[i] = rnd ? DW'($urandom) : DW'(base + i);
        for (int i = 0; i < N; i++) begin
            send_q[r].push_back(w[i]);
            in_exp[r].push_back(w[i]);
        end
        for (int j = 0; j < N; j++) out_exp[r].push_back(w[bitrev(j)]);
    endtask

    task automatic clear_tb();
        for (int r = 0; r < NR; r++) begin
            send_q[r].delete();
            in_exp[r].delete();
            out_exp[r].delete();
            pause_beat[r] = -1;
        end
        grant_log.delete();
        in_beat  = 0;
        hold_rsp = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_tb();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic bit pending();
        for (int r = 0; r < NR; r++)
            if (send_q[r].size() != 0 || out_exp[r].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drain(input string tag);
        int cyc = 0;
        while (pending() && cyc < 3000) begin
            @(posedge clk);
            cyc++;
        end
        if (pending()) fail_now({tag, "_drain"});
        repeat (2) @(negedge clk);
        check({tag, "_busy_idle"}, 64'(busy), 64'd0);
    endtask

    task automatic wait_beat(input int target, input string tag);
        int cyc = 0;
        do begin
            @(posedge clk);
            cyc++;
        end while (in_beat != target && cyc < 500);
        if (in_beat != target) fail_now(tag);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"},  64'(req_ready),      64'd0);
        check({tag, "_rsp_valid"},  64'(rsp_valid),      64'd0);
        check({tag, "_core_valid"}, 64'(dut_core_valid), 64'd0);
        check({tag, "_core_ready"}, 64'(dut_core_ready), 64'd0);
        check({tag, "_busy"},       64'(busy),           64'd0);
        check({tag, "_core_data"},  64'(dut_core_data),  64'd0);
        check({tag, "_rsp_data"},   rsp_data,            64'd0);
    endtask

    task automatic check_grants(input string tag, input int exp_g[$]);
        check({tag, "_grant_count"}, 64'(grant_log.size()), 64'(exp_g.size()));
        for (int i = 0; i < exp_g.size(); i++)
            check({tag, "_grant"}, (i < grant_log.size()) ? 64'(grant_log[i]) : '1, 64'(exp_g[i]));
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        clear_tb();
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Single requester, sequential data.
        queue_frame(0, 1'b0, 0);
        @(posedge clk);
        repeat (3) @(negedge clk);
        check("t1_busy_active", 64'(busy), 64'd1);
        drain("t1");
        check_grants("t1", '{0});

        // Both requesters always valid: strict rotation.
        do_reset();
        queue_frame(0, 1'b0, 0);
        queue_frame(1, 1'b0, 100);
        queue_frame(0, 1'b1, 0);
        drain("t2");
        check_grants("t2", '{0, 1, 0});

        // Port 0 output stalled: second frame accepted, third blocked by full FIFO.
        do_reset();
        hold_rsp[0] = 1'b1;
        queue_frame(0, 1'b1, 0);
        queue_frame(1, 1'b1, 0);
        queue_frame(0, 1'b1, 0);
        repeat (40) @(negedge clk);
        check_grants("t3_stalled", '{0, 1});
        check("t3_blocked_ready", 64'(req_ready), 64'd0);
        check("t3_busy", 64'(busy), 64'd1);
        hold_rsp[0] = 1'b0;
        drain("t3");
        check_grants("t3", '{0, 1, 0});

        // Granted requester drops valid for 5 cycles after beat 7.
        do_reset();
        pause_beat[0] = 8;
        pause_len     = 5;
        queue_frame(0, 1'b1, 0);
        queue_frame(1, 1'b1, 0);
        wait_beat(8, "t4_beat8");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_pause_core_valid", 64'(dut_core_valid), 64'd0);
            check("t4_pause_req1_ready", 64'(req_ready[1]), 64'd0);
        end
        drain("t4");
        check_grants("t4", '{0, 1});

        // Reset mid-frame, then a fresh frame from requester 1.
        do_reset();
        queue_frame(0, 1'b1, 0);
        wait_beat(9, "t5_beat9");
        @(negedge clk);
        rst_n = 1'b0;
        clear_tb();
        #1;
        check_reset_outputs("t5_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        queue_frame(1, 1'b0, 100);
        drain("t5");
        check_grants("t5", '{1});

        // Randomised traffic with random response back-pressure.
        do_reset();
        rand_rdy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            queue_frame(int'($urandom_range(0, NR - 1)), 1'b1, 0);
            repeat ($urandom_range(0, 20)) @(posedge clk);
        end
        drain("t6");
        rand_rdy = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
